// File: rtl/scene_sched.sv
// Scene scheduler: picks the displayed scene, inserts black frames on
// every switch, and runs an optional timed slideshow.
module scene_sched #(
    parameter int N_SCENES     = 3,
    parameter int DWELL_FRAMES = 300,
    parameter int BLANK_FRAMES = 2,
    parameter bit AUTO_DEFAULT = 1'b1
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    input  logic       frame_tick,
    input  logic       key_next,
    input  logic       key_prev,
    input  logic       key_mode,
    output logic [1:0] scene_sel,
    output logic       blank,
    output logic       auto_mode,
    output logic       busy
);

    typedef enum logic [1:0] {SHOW, WAIT_FB, BLANK} state_t;

    localparam logic [1:0]  LAST     = 2'(N_SCENES - 1);
    localparam logic [15:0] DW_LAST  = 16'(DWELL_FRAMES - 1);
    localparam logic [7:0]  BL_LAST  = 8'(BLANK_FRAMES - 1);
    localparam bit          NO_BLANK = (BLANK_FRAMES == 0);

    state_t      state, state_n;
    logic [1:0]  scene_n;
    logic        blank_n, auto_n, busy_n;
    logic [15:0] dwell, dwell_n;
    logic [7:0]  bcnt, bcnt_n;
    logic        dir, dir_n;
    logic        pend, pend_n;
    logic        pdir, pdir_n;
    logic        req, expire, fwd;

    function automatic logic [1:0] step(input logic [1:0] s, input logic nxt);
        if (nxt) return (s == LAST) ? 2'd0 : s + 2'd1;
        return (s == 2'd0) ? LAST : s - 2'd1;
    endfunction

    always_comb begin
        state_n = state;
        scene_n = scene_sel;
        blank_n = blank;
        auto_n  = auto_mode;
        dwell_n = dwell;
        bcnt_n  = bcnt;
        dir_n   = dir;
        pend_n  = pend;
        pdir_n  = pdir;
        fwd     = 1'b1;
        req     = key_next | key_prev;
        expire  = frame_tick && auto_mode && !key_mode && (dwell == DW_LAST);

        unique case (state)
            SHOW: begin
                if (expire) begin
                    // a coinciding key or queued request picks the direction
                    fwd     = req ? key_next : (pend ? pdir : 1'b1);
                    scene_n = step(scene_sel, fwd);
                    pend_n  = 1'b0;
                    bcnt_n  = 8'd0;
                    state_n = NO_BLANK ? SHOW : BLANK;
                    blank_n = !NO_BLANK;
                    dwell_n = 16'd0;
                end else if (req || pend) begin
                    state_n = WAIT_FB;
                    dir_n   = req ? key_next : pdir;
                    pend_n  = 1'b0;
                    dwell_n = 16'd0;
                end else if (frame_tick && auto_mode) begin
                    dwell_n = dwell + 16'd1;
                end
            end
            WAIT_FB: begin
                if (req) begin
                    pend_n = 1'b1;
                    pdir_n = key_next;
                end
                if (frame_tick) begin
                    scene_n = step(scene_sel, dir);
                    bcnt_n  = 8'd0;
                    state_n = NO_BLANK ? SHOW : BLANK;
                    blank_n = !NO_BLANK;
                end
            end
            BLANK: begin
                if (req) begin
                    pend_n = 1'b1;
                    pdir_n = key_next;
                end
                if (frame_tick) begin
                    if (bcnt == BL_LAST) begin
                        state_n = SHOW;
                        blank_n = 1'b0;
                    end else begin
                        bcnt_n = bcnt + 8'd1;
                    end
                end
            end
            default: begin
                state_n = SHOW;
                blank_n = 1'b0;
            end
        endcase

        if (key_mode) begin
            auto_n  = !auto_mode;
            dwell_n = 16'd0;
        end
        if (state_n != SHOW || !auto_n) dwell_n = 16'd0;
        busy_n = (state_n != SHOW);
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= SHOW;
            scene_sel <= 2'd0;
            blank     <= 1'b0;
            busy      <= 1'b0;
            auto_mode <= AUTO_DEFAULT;
            dwell     <= 16'd0;
            bcnt      <= 8'd0;
            dir       <= 1'b1;
            pend      <= 1'b0;
            pdir      <= 1'b1;
        end else begin
            state     <= state_n;
            scene_sel <= scene_n;
            blank     <= blank_n;
            busy      <= busy_n;
            auto_mode <= auto_n;
            dwell     <= dwell_n;
            bcnt      <= bcnt_n;
            dir       <= dir_n;
            pend      <= pend_n;
            pdir      <= pdir_n;
        end
    end

endmodule

// File: tb/tb_scene_sched.sv
// Bench for scene_sched: directed scenarios plus random stimulus
// checked against a behavioural model of the scheduling rules.
module tb_scene_sched;

    localparam int N  = 3;
    localparam int DW = 4;
    localparam int BF = 2;

    logic       vga_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       key_next = 1'b0;
    logic       key_prev = 1'b0;
    logic       key_mode = 1'b0;
    logic [1:0] scene_sel;
    logic       blank;
    logic       auto_mode;
    logic       busy;

    int total = 0;
    int passed = 0;
    int failed = 0;

    scene_sched #(
        .N_SCENES(N), .DWELL_FRAMES(DW),
        .BLANK_FRAMES(BF), .AUTO_DEFAULT(1'b0)
    ) dut (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n),
        .frame_tick(frame_tick), .key_next(key_next),
        .key_prev(key_prev), .key_mode(key_mode),
        .scene_sel(scene_sel), .blank(blank),
        .auto_mode(auto_mode), .busy(busy)
    );

    always #5 vga_clk = ~vga_clk;

    // phase: 0 showing, 1 waiting for frame boundary, 2 blanking
    int m_scene, m_phase, m_left, m_dwell, m_dir;
    bit m_auto;
    int q[$];

    function automatic void m_reset();
        m_scene = 0; m_phase = 0; m_left = 0;
        m_dwell = 0; m_dir = 1; m_auto = 1'b0;
        q.delete();
    endfunction

    function automatic void m_switch(int d);
        m_scene = (m_scene + d + N) % N;
        m_dwell = 0;
        if (BF == 0) m_phase = 0;
        else begin
            m_phase = 2;
            m_left = BF;
        end
    endfunction

    function automatic void m_step(bit ft, bit kn, bit kp, bit km);
        bit key = kn | kp;
        int kd = kn ? 1 : -1;
        bit have;
        int d;
        case (m_phase)
            0: begin
                have = key || (q.size() > 0);
                d = key ? kd : ((q.size() > 0) ? q[0] : 1);
                q.delete();
                if (ft && m_auto && !km && m_dwell == DW - 1)
                    m_switch(d);
                else if (have) begin
                    m_phase = 1;
                    m_dir = d;
                    m_dwell = 0;
                end else if (ft && m_auto && !km)
                    m_dwell++;
            end
            1: begin
                if (key) q = '{kd};
                if (ft) m_switch(m_dir);
            end
            default: begin
                if (key) q = '{kd};
                if (ft) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 0;
                        m_dwell = 0;
                    end
                end
            end
        endcase
        if (km) begin
            m_auto = !m_auto;
            m_dwell = 0;
        end
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic compare();
        chk("scene_sel", 16'(scene_sel), 16'(m_scene));
        chk("blank", 16'(blank), 16'(m_phase == 2));
        chk("busy", 16'(busy), 16'(m_phase != 0));
        chk("auto_mode", 16'(auto_mode), 16'(m_auto));
    endtask

    task automatic cyc(input bit ft, input bit kn,
                       input bit kp, input bit km);
        frame_tick = ft; key_next = kn; key_prev = kp; key_mode = km;
        @(posedge vga_clk);
        m_step(ft, kn, kp, km);
        #1;
        frame_tick = 0; key_next = 0; key_prev = 0; key_mode = 0;
        compare();
    endtask

    task automatic key_switch(input bit kn, input bit kp);
        cyc(0, kn, kp, 0);
        repeat (3) cyc(1, 0, 0, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_scene"}, 16'(scene_sel), 16'd0);
        chk({tag, "_blank"}, 16'(blank), 16'd0);
        chk({tag, "_busy"}, 16'(busy), 16'd0);
        chk({tag, "_auto"}, 16'(auto_mode), 16'd0);
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge vga_clk);
        #3 sys_rst_n = 1'b1;
        @(posedge vga_clk);
        #1 chk_reset_vals("rst");
        repeat (3) cyc(1, 0, 0, 0);
        chk_reset_vals("idle");

        // key_next then frame ticks
        cyc(0, 1, 0, 0);
        chk("next_busy", 16'(busy), 16'd1);
        cyc(1, 0, 0, 0);
        chk("next_scene", 16'(scene_sel), 16'd1);
        chk("next_blank", 16'(blank), 16'd1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("next_unblank", 16'(blank), 16'd0);
        chk("next_idle", 16'(busy), 16'd0);

        // prev wrap from scene 0
        key_switch(0, 1);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("prev_wrap", 16'(scene_sel), 16'd2);
        repeat (2) cyc(1, 0, 0, 0);

        // back to 0, then auto mode slideshow
        key_switch(1, 0);
        cyc(0, 0, 0, 1);
        chk("auto_on", 16'(auto_mode), 16'd1);
        repeat (3) cyc(1, 0, 0, 0);
        chk("auto_hold", 16'(scene_sel), 16'd0);
        chk("auto_nowait", 16'(busy), 16'd0);
        cyc(1, 0, 0, 0);
        chk("auto_adv", 16'(scene_sel), 16'd1);
        chk("auto_blank", 16'(blank), 16'd1);
        repeat (2) cyc(1, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);
        chk("auto_hold2", 16'(scene_sel), 16'd1);
        cyc(1, 0, 0, 0);
        chk("auto_adv2", 16'(scene_sel), 16'd2);
        repeat (2) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk("auto_off", 16'(auto_mode), 16'd0);

        // key during BLANK queues a second switch
        key_switch(1, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("q_first", 16'(scene_sel), 16'd1);
        cyc(0, 1, 0, 0);
        repeat (2) cyc(1, 0, 0, 0);
        chk("q_unblank", 16'(blank), 16'd0);
        cyc(0, 0, 0, 0);
        chk("q_wait", 16'(busy), 16'd1);
        cyc(1, 0, 0, 0);
        chk("q_second", 16'(scene_sel), 16'd2);
        repeat (2) cyc(1, 0, 0, 0);

        // reset mid-BLANK
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rb_blank", 16'(blank), 16'd1);
        #2 sys_rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        m_reset();
        @(posedge vga_clk);
        #3 sys_rst_n = 1'b1;
        repeat (4) cyc(1, 0, 0, 0);
        chk_reset_vals("post_rst");

        // random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(2) == 0), ($urandom_range(7) == 0),
                ($urandom_range(7) == 0), ($urandom_range(15) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
